// File: rtl/padd_pkg.sv
// Shared definitions for the pipelined-adder scheduler.
//   PADD_W    operand/sum width
//   PADD_LAT  adder latency (input sampled -> sum valid)
//   PADD_IDW  requester ID width
//   padd_tag_t  in-flight tag {valid, id}
//   padd_op_t   registered adder operation {a, b, ci}
package padd_pkg;
    localparam int PADD_W   = 4;
    localparam int PADD_LAT = 4;
    localparam int PADD_IDW = 2;

    typedef struct packed {
        logic                valid;
        logic [PADD_IDW-1:0] id;
    } padd_tag_t;

    typedef struct packed {
        logic [PADD_W-1:0] a;
        logic [PADD_W-1:0] b;
        logic              ci;
    } padd_op_t;
endpackage

// File: rtl/padd_rr_arb.sv
// NREQ-way arbiter: one-hot combinational grant among req, gated by en.
// Round-robin by default; the pointer moves to the winner whenever a grant
// is issued (a grant is only ever given to a valid request, so a grant is
// a handshake).
// Build option: PADD_SCHED_FIXED_PRI_EN -> fixed priority, lowest index wins,
// no pointer register.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   en          grant enable
//   req         per-requester request
//   gnt         one-hot grant
//   gnt_idx     index of the granted requester
//   gnt_vld     a grant is issued this cycle
module padd_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_vld
);
    int idx;

`ifndef PADD_SCHED_FIXED_PRI_EN
    logic [IDW-1:0] ptr;

    // Reset to NREQ-1 so the first search starts at requester 0.
    always_ff @(posedge clk) begin
        if (!rstn)
            ptr <= IDW'(NREQ - 1);
        else if (gnt_vld)
            ptr <= gnt_idx;
    end
`endif

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
`ifdef PADD_SCHED_FIXED_PRI_EN
                idx = k - 1;
`else
                idx = (int'(ptr) + k) % NREQ;
`endif
                if (!gnt_vld && req[idx]) begin
                    gnt_vld  = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = IDW'(idx);
                end
            end
        end
    end
endmodule

// File: rtl/padd_rr_sched.sv
// Shares one pipelined adder among NREQ requesters. One operation accepted
// per cycle (valid/ready), registered onto the adder ports; a tag pipeline
// of LAT+1 stages follows each op so the adder result comes back tagged
// with its requester ID.
// Build option: PADD_SCHED_FIXED_PRI_EN selects fixed priority arbitration.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   en                   issue enable (in-flight ops always drain)
//   req_valid/req_ready  per-requester handshake, ready is one-hot
//   req_a/req_b/req_ci   packed operands, requester i at [i*W +: W]
//   add_a/add_b/add_ci   registered adder operands (0 on bubbles)
//   add_s/add_co         adder result
//   rsp_valid/rsp_id     tagged result strobe
//   rsp_s/rsp_co         result data, 0 when rsp_valid is low
//   busy                 any op in flight
module padd_rr_sched
    import padd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = PADD_W,
    parameter int LAT  = PADD_LAT,
    parameter int IDW  = PADD_IDW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_ci,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_ci,
    input  logic [W-1:0]      add_s,
    input  logic              add_co,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_s,
    output logic              rsp_co,
    output logic              busy
);
    logic           hs;
    logic [IDW-1:0] win;
    padd_op_t       op_q;
    padd_tag_t      tags [LAT+1];

    padd_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (win),
        .gnt_vld (hs)
    );

    // Bubbles drive zero operands so the adder sees a defined input.
    always_ff @(posedge clk) begin
        if (!rstn)
            op_q <= '0;
        else if (hs)
            op_q <= '{a: req_a[win*W +: W], b: req_b[win*W +: W], ci: req_ci[win]};
        else
            op_q <= '0;
    end

    assign add_a  = op_q.a;
    assign add_b  = op_q.b;
    assign add_ci = op_q.ci;

    // Stage 0 aligns with the operand register; stage LAT lines up with
    // the adder output.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i <= LAT; i++)
                tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: hs, id: win};
            for (int i = 1; i <= LAT; i++)
                tags[i] <= tags[i-1];
        end
    end

    assign rsp_valid = tags[LAT].valid;
    assign rsp_id    = tags[LAT].id;
    assign rsp_s     = rsp_valid ? add_s  : '0;
    assign rsp_co    = rsp_valid ? add_co : 1'b0;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LAT; i++)
            busy = busy | tags[i].valid;
    end
endmodule

// File: tb/tb_padd_rr_sched.sv
module tb_padd_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int LAT  = 4;

    logic            clk = 1'b0;
    logic            rstn, en;
    logic [NREQ-1:0] req_valid, req_ci, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [W-1:0]    add_a, add_b, add_s, rsp_s;
    logic            add_ci, add_co, rsp_valid, rsp_co, busy;
    logic [1:0]      rsp_id;

    padd_rr_sched dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in adder: LAT register stages, never reset, so stale sums keep
    // flowing after a scheduler reset.
    logic [W:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_s  = apipe[LAT-1][W-1:0];
    assign add_co = apipe[LAT-1][W];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected responses as a queue of due-cycle records.
    typedef struct {
        int due;
        int id;
        int sum;
    } rsp_rec_t;

    rsp_rec_t q[$];
    int cyc    = 0;
    int ptr    = NREQ - 1;
    int prev_a = 0, prev_b = 0, prev_ci = 0;
    bit chk_on = 0;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic step();
        int       w;
        rsp_rec_t r;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        w = en ? pick(req_valid, ptr) : -1;
        exp_rdy = (w >= 0) ? NREQ'(1 << w) : '0;
        if (chk_on) begin
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            check_eq("add_a", 32'(add_a), 32'(prev_a));
            check_eq("add_b", 32'(add_b), 32'(prev_b));
            check_eq("add_ci", 32'(add_ci), 32'(prev_ci));
            check_eq("busy", 32'(busy), 32'(q.size() != 0));
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
                check_eq("rsp_id", 32'(rsp_id), 32'(r.id));
                check_eq("rsp_s", 32'(rsp_s), 32'(r.sum % 16));
                check_eq("rsp_co", 32'(rsp_co), 32'(r.sum / 16));
            end else begin
                check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                check_eq("rsp_s_idle", 32'(rsp_s), 32'd0);
                check_eq("rsp_co_idle", 32'(rsp_co), 32'd0);
            end
        end
        if (!rstn) begin
            q.delete();
            ptr = NREQ - 1;
            prev_a = 0; prev_b = 0; prev_ci = 0;
        end else if (w >= 0) begin
            prev_a  = int'(req_a[w*W +: W]);
            prev_b  = int'(req_b[w*W +: W]);
            prev_ci = int'(req_ci[w]);
            r.due = cyc + LAT + 1;
            r.id  = w;
            r.sum = prev_a + prev_b + prev_ci;
            q.push_back(r);
            ptr = w;
        end else begin
            prev_a = 0; prev_b = 0; prev_ci = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        req_a  = NREQ*W'($urandom);
        req_b  = NREQ*W'($urandom);
        req_ci = NREQ'($urandom);
    endtask

    task automatic run(input int n, input bit r, input bit e, input logic [NREQ-1:0] v);
        for (int i = 0; i < n; i++) begin
            rstn = r; en = e; req_valid = v;
            rand_ops();
            step();
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0; req_ci = '0;
        @(posedge clk); #1;
        run(2, 0, 0, 4'b0000);
        chk_on = 1;
        run(2, 1, 1, 4'b0000);

        // single op from requester 2: 7 + 9 + 1 = 0x11
        rstn = 1; en = 1; req_valid = 4'b0100;
        req_a = 16'h0700; req_b = 16'h0900; req_ci = 4'b0100;
        step();
        run(7, 1, 1, 4'b0000);

        // all requesters, then 1 and 3 only
        run(12, 1, 1, 4'b1111);
        run(8, 1, 1, 4'b1010);
        run(6, 1, 1, 4'b0000);

        // two ops, then en low for 3 cycles with everyone requesting
        run(2, 1, 1, 4'b1111);
        run(3, 1, 0, 4'b1111);
        run(3, 1, 1, 4'b1111);
        run(6, 1, 1, 4'b0000);

        // reset with 3 in flight, then first grant must go to requester 0
        run(3, 1, 1, 4'b1111);
        run(1, 0, 1, 4'b1111);
        run(6, 1, 1, 4'b0000);
        run(2, 1, 1, 4'b1111);
        run(6, 1, 1, 4'b0000);

        // edge values
        rstn = 1; en = 1; req_valid = 4'b0001;
        req_a = 16'h000F; req_b = 16'h000F; req_ci = 4'b0001;
        step();
        req_a = 16'h0000; req_b = 16'h0000; req_ci = 4'b0000;
        step();
        run(6, 1, 1, 4'b0000);

        // random traffic
        for (int i = 0; i < 400; i++)
            run(1, ($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), NREQ'($urandom));
        run(7, 1, 1, 4'b0000);

        check_eq("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
